// File: rtl/iic_reg_arbiter.sv
// Two-requester arbiter for the IIC master core register bus.
// Ownership spans a whole transaction; a hold-time watchdog revokes a stuck owner and forces STOP.

module iic_reg_arbiter_chk #(
  parameter logic [7:0] STOP_CMD = 8'h40
) (
  input  logic       I_CLK,
  input  logic       I_RESETN,
  input  logic       R0_GNT,
  input  logic       R1_GNT,
  input  logic       I_TX_EN,
  input  logic [2:0] I_WADDR,
  input  logic [7:0] I_WDATA,
  input  logic       I_RX_EN
);

  a_gnt_onehot: assert property (@(posedge I_CLK) disable iff (!I_RESETN)
    !(R0_GNT && R1_GNT));

  a_rx_owned: assert property (@(posedge I_CLK) disable iff (!I_RESETN)
    I_RX_EN |-> (R0_GNT || R1_GNT));

  // An ungranted write can only be the forced STOP.
  a_tx_stop: assert property (@(posedge I_CLK) disable iff (!I_RESETN)
    (I_TX_EN && !R0_GNT && !R1_GNT) |-> ((I_WADDR == 3'b100) && (I_WDATA == STOP_CMD)));

endmodule

module iic_reg_arbiter #(
  parameter logic [15:0] HOLD_MAX = 16'd4096,
  parameter logic [7:0]  STOP_CMD = 8'h40
) (
  input  logic       I_CLK,
  input  logic       I_RESETN,
  input  logic       R0_REQ,
  input  logic       R1_REQ,
  output logic       R0_GNT,
  output logic       R1_GNT,
  input  logic       R0_TX_EN,
  input  logic [2:0] R0_WADDR,
  input  logic [7:0] R0_WDATA,
  input  logic       R0_RX_EN,
  input  logic [2:0] R0_RADDR,
  output logic [7:0] R0_RDATA,
  input  logic       R1_TX_EN,
  input  logic [2:0] R1_WADDR,
  input  logic [7:0] R1_WDATA,
  input  logic       R1_RX_EN,
  input  logic [2:0] R1_RADDR,
  output logic [7:0] R1_RDATA,
  output logic       I_TX_EN,
  output logic [2:0] I_WADDR,
  output logic [7:0] I_WDATA,
  output logic       I_RX_EN,
  output logic [2:0] I_RADDR,
  input  logic [7:0] O_RDATA,
  output logic [1:0] TO_FLAG,
  output logic [1:0] DROP_FLAG
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_OWN0  = 3'd1,
    ST_OWN1  = 3'd2,
    ST_ABORT = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        last_owner_r;
  logic [1:0]  blocked_r;
  logic [15:0] hold_cnt_r;
  logic [1:0]  to_flag_r;
  logic [1:0]  drop_flag_r;

  logic [1:0]  req_s;
  logic [1:0]  strobe_s;
  logic [1:0]  elig_s;
  logic [1:0]  gnt_s;
  logic [1:0]  rel_s;
  logic [1:0]  rev_s;
  logic        hold_exp_s;

  assign req_s      = {R1_REQ, R0_REQ};
  assign strobe_s   = {R1_TX_EN | R1_RX_EN, R0_TX_EN | R0_RX_EN};
  assign elig_s     = req_s & ~blocked_r;
  assign hold_exp_s = (HOLD_MAX != 16'd0) && (hold_cnt_r == (HOLD_MAX - 16'd1));
  assign rel_s      = gnt_s & ~req_s;
  assign rev_s      = gnt_s & req_s & {2{hold_exp_s}};

  always_ff @(posedge I_CLK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (elig_s == 2'b11) begin
          state_nxt_s = last_owner_r ? ST_OWN0 : ST_OWN1;
        end else if (elig_s[0]) begin
          state_nxt_s = ST_OWN0;
        end else if (elig_s[1]) begin
          state_nxt_s = ST_OWN1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_OWN0: begin
        if (!R0_REQ) begin
          state_nxt_s = ST_GAP;
        end else if (hold_exp_s) begin
          state_nxt_s = ST_ABORT;
        end else begin
          state_nxt_s = ST_OWN0;
        end
      end
      ST_OWN1: begin
        if (!R1_REQ) begin
          state_nxt_s = ST_GAP;
        end else if (hold_exp_s) begin
          state_nxt_s = ST_ABORT;
        end else begin
          state_nxt_s = ST_OWN1;
        end
      end
      ST_ABORT: state_nxt_s = ST_GAP;
      ST_GAP:   state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Release beats expiry; blocked set and clear are exclusive since setting needs REQ high.
  always_ff @(posedge I_CLK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      last_owner_r <= 1'b1;
      blocked_r    <= 2'b00;
      hold_cnt_r   <= 16'd0;
      to_flag_r    <= 2'b00;
      drop_flag_r  <= 2'b00;
    end else begin
      hold_cnt_r  <= (|gnt_s) ? (hold_cnt_r + 16'd1) : 16'd0;
      blocked_r   <= (blocked_r & req_s) | rev_s;
      to_flag_r   <= to_flag_r | rev_s;
      drop_flag_r <= drop_flag_r | (strobe_s & ~gnt_s);
      if (|(rel_s | rev_s)) begin
        last_owner_r <= gnt_s[1];
      end
    end
  end

  always_comb begin
    gnt_s   = 2'b00;
    I_TX_EN = 1'b0;
    I_WADDR = 3'b000;
    I_WDATA = 8'h00;
    I_RX_EN = 1'b0;
    I_RADDR = 3'b000;
    case (state_r)
      ST_OWN0: begin
        gnt_s   = 2'b01;
        I_TX_EN = R0_TX_EN;
        I_WADDR = R0_WADDR;
        I_WDATA = R0_WDATA;
        I_RX_EN = R0_RX_EN;
        I_RADDR = R0_RADDR;
      end
      ST_OWN1: begin
        gnt_s   = 2'b10;
        I_TX_EN = R1_TX_EN;
        I_WADDR = R1_WADDR;
        I_WDATA = R1_WDATA;
        I_RX_EN = R1_RX_EN;
        I_RADDR = R1_RADDR;
      end
      ST_ABORT: begin
        I_TX_EN = 1'b1;
        I_WADDR = 3'b100;
        I_WDATA = STOP_CMD;
      end
      default: gnt_s = 2'b00;
    endcase
    R0_RDATA = gnt_s[0] ? O_RDATA : 8'h00;
    R1_RDATA = gnt_s[1] ? O_RDATA : 8'h00;
  end

  assign R0_GNT    = gnt_s[0];
  assign R1_GNT    = gnt_s[1];
  assign TO_FLAG   = to_flag_r;
  assign DROP_FLAG = drop_flag_r;

  iic_reg_arbiter_chk #(
    .STOP_CMD (STOP_CMD)
  ) u_chk (
    .I_CLK    (I_CLK),
    .I_RESETN (I_RESETN),
    .R0_GNT   (R0_GNT),
    .R1_GNT   (R1_GNT),
    .I_TX_EN  (I_TX_EN),
    .I_WADDR  (I_WADDR),
    .I_WDATA  (I_WDATA),
    .I_RX_EN  (I_RX_EN)
  );

endmodule

// File: tb/tb_iic_reg_arbiter.sv
// Bench for iic_reg_arbiter: fixed vector table, hand-written corner sequences,
// then random traffic checked against a transaction-level ownership model.

module tb_iic_reg_arbiter;

  localparam int         HM   = 8;
  localparam logic [7:0] STOP = 8'h40;

  logic       I_CLK, I_RESETN;
  logic       R0_REQ, R1_REQ, R0_GNT, R1_GNT;
  logic       R0_TX_EN, R0_RX_EN, R1_TX_EN, R1_RX_EN;
  logic [2:0] R0_WADDR, R0_RADDR, R1_WADDR, R1_RADDR;
  logic [7:0] R0_WDATA, R1_WDATA, R0_RDATA, R1_RDATA;
  logic       I_TX_EN, I_RX_EN;
  logic [2:0] I_WADDR, I_RADDR;
  logic [7:0] I_WDATA, O_RDATA;
  logic [1:0] TO_FLAG, DROP_FLAG;

  int n_cmp = 0;
  int n_fail = 0;

  iic_reg_arbiter #(.HOLD_MAX(16'(HM)), .STOP_CMD(STOP)) dut (
    .I_CLK(I_CLK), .I_RESETN(I_RESETN),
    .R0_REQ(R0_REQ), .R1_REQ(R1_REQ), .R0_GNT(R0_GNT), .R1_GNT(R1_GNT),
    .R0_TX_EN(R0_TX_EN), .R0_WADDR(R0_WADDR), .R0_WDATA(R0_WDATA),
    .R0_RX_EN(R0_RX_EN), .R0_RADDR(R0_RADDR), .R0_RDATA(R0_RDATA),
    .R1_TX_EN(R1_TX_EN), .R1_WADDR(R1_WADDR), .R1_WDATA(R1_WDATA),
    .R1_RX_EN(R1_RX_EN), .R1_RADDR(R1_RADDR), .R1_RDATA(R1_RDATA),
    .I_TX_EN(I_TX_EN), .I_WADDR(I_WADDR), .I_WDATA(I_WDATA),
    .I_RX_EN(I_RX_EN), .I_RADDR(I_RADDR), .O_RDATA(O_RDATA),
    .TO_FLAG(TO_FLAG), .DROP_FLAG(DROP_FLAG)
  );

  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  // Reference model: who owns the bus and what phase the hand-over is in.
  int         m_owner, m_held, m_last;
  bit         m_abort, m_gap;
  logic [1:0] m_blocked, m_to, m_drop;

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_last = 1; m_abort = 1'b0; m_gap = 1'b0;
    m_blocked = 2'b00; m_to = 2'b00; m_drop = 2'b00;
  endtask

  function automatic logic [37:0] model_out();
    logic [1:0] g; logic [15:0] core; logic [7:0] d0, d1;
    g = 2'b00; core = 16'h0000; d0 = 8'h00; d1 = 8'h00;
    if (m_owner == 0) begin
      g = 2'b01; d0 = O_RDATA;
      core = {R0_TX_EN, R0_WADDR, R0_WDATA, R0_RX_EN, R0_RADDR};
    end else if (m_owner == 1) begin
      g = 2'b10; d1 = O_RDATA;
      core = {R1_TX_EN, R1_WADDR, R1_WDATA, R1_RX_EN, R1_RADDR};
    end else if (m_abort) begin
      core = {1'b1, 3'b100, STOP, 1'b0, 3'b000};
    end
    return {g, core, d0, d1, m_to, m_drop};
  endfunction

  task automatic model_tick();
    logic [1:0] req, stb, elig, nb;
    req = {R1_REQ, R0_REQ};
    stb = {R1_TX_EN | R1_RX_EN, R0_TX_EN | R0_RX_EN};
    for (int n = 0; n < 2; n++)
      if (stb[n] && m_owner != n) m_drop[n] = 1'b1;
    nb = m_blocked & req;
    if (m_owner >= 0) begin
      m_held++;
      if (!req[m_owner]) begin
        m_last = m_owner; m_owner = -1; m_gap = 1'b1;
      end else if (m_held == HM) begin
        m_to[m_owner] = 1'b1; nb[m_owner] = 1'b1;
        m_last = m_owner; m_owner = -1; m_abort = 1'b1;
      end
    end else if (m_abort) begin
      m_abort = 1'b0; m_gap = 1'b1;
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else begin
      elig = req & ~m_blocked;
      if (elig == 2'b11) m_owner = 1 - m_last;
      else if (elig[0]) m_owner = 0;
      else if (elig[1]) m_owner = 1;
      m_held = 0;
    end
    m_blocked = nb;
  endtask

  function automatic logic [37:0] dut_out();
    return {R1_GNT, R0_GNT, I_TX_EN, I_WADDR, I_WDATA, I_RX_EN, I_RADDR,
            R0_RDATA, R1_RDATA, TO_FLAG, DROP_FLAG};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic sample();
    #1;
    chk("cycle_model", 64'(dut_out()), 64'(model_out()));
  endtask

  task automatic tick();
    @(posedge I_CLK);
    if (I_RESETN) model_tick();
    else model_reset();
    @(negedge I_CLK);
  endtask

  task automatic step();
    sample();
    tick();
  endtask

  task automatic clear_inputs();
    R0_REQ = 1'b0; R1_REQ = 1'b0;
    {R0_TX_EN, R0_WADDR, R0_WDATA, R0_RX_EN, R0_RADDR} = 16'h0000;
    {R1_TX_EN, R1_WADDR, R1_WDATA, R1_RX_EN, R1_RADDR} = 16'h0000;
    O_RDATA = 8'h00;
  endtask

  task automatic do_reset();
    I_RESETN = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge I_CLK);
    I_RESETN = 1'b1;
  endtask

  function automatic logic [15:0] bus(input logic tx, input logic [2:0] wa, input logic [7:0] wd,
                                      input logic rx, input logic [2:0] ra);
    return {tx, wa, wd, rx, ra};
  endfunction

  typedef struct packed {
    logic [1:0]  req;
    logic [15:0] r0_bus;
    logic [15:0] r1_bus;
    logic [7:0]  rdata;
    logic [1:0]  e_gnt;
    logic [15:0] e_core;
    logic [7:0]  e_r0d;
    logic [7:0]  e_r1d;
    logic [1:0]  e_drop;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  gnt_cycles;
    bit  fell;

    tbl[0]  = '{2'b01, 16'h0, 16'h0, 8'h00, 2'b00, 16'h0, 8'h00, 8'h00, 2'b00};
    tbl[1]  = '{2'b01, bus(1'b1, 3'd0, 8'h63, 1'b0, 3'd0), 16'h0, 8'h00,
                2'b01, bus(1'b1, 3'd0, 8'h63, 1'b0, 3'd0), 8'h00, 8'h00, 2'b00};
    tbl[2]  = '{2'b01, bus(1'b0, 3'd0, 8'h00, 1'b1, 3'd4), bus(1'b1, 3'd3, 8'hA0, 1'b0, 3'd0), 8'h02,
                2'b01, bus(1'b0, 3'd0, 8'h00, 1'b1, 3'd4), 8'h02, 8'h00, 2'b00};
    tbl[3]  = '{2'b00, 16'h0, 16'h0, 8'h02, 2'b01, 16'h0, 8'h02, 8'h00, 2'b10};
    tbl[4]  = '{2'b00, 16'h0, 16'h0, 8'h55, 2'b00, 16'h0, 8'h00, 8'h00, 2'b10};
    tbl[5]  = '{2'b11, 16'h0, 16'h0, 8'h00, 2'b00, 16'h0, 8'h00, 8'h00, 2'b10};
    tbl[6]  = '{2'b11, bus(1'b1, 3'd1, 8'h11, 1'b0, 3'd0), bus(1'b1, 3'd5, 8'h3C, 1'b0, 3'd0), 8'h77,
                2'b10, bus(1'b1, 3'd5, 8'h3C, 1'b0, 3'd0), 8'h00, 8'h77, 2'b10};
    tbl[7]  = '{2'b01, 16'h0, 16'h0, 8'h77, 2'b10, 16'h0, 8'h00, 8'h77, 2'b11};
    tbl[8]  = '{2'b01, 16'h0, 16'h0, 8'h00, 2'b00, 16'h0, 8'h00, 8'h00, 2'b11};
    tbl[9]  = '{2'b01, 16'h0, 16'h0, 8'h00, 2'b00, 16'h0, 8'h00, 8'h00, 2'b11};
    tbl[10] = '{2'b01, bus(1'b1, 3'd2, 8'hF0, 1'b1, 3'd6), 16'h0, 8'h00,
                2'b01, bus(1'b1, 3'd2, 8'hF0, 1'b1, 3'd6), 8'h00, 8'h00, 2'b11};
    tbl[11] = '{2'b00, 16'h0, 16'h0, 8'h00, 2'b01, 16'h0, 8'h00, 8'h00, 2'b11};
    tbl[12] = '{2'b00, 16'h0, 16'h0, 8'h00, 2'b00, 16'h0, 8'h00, 8'h00, 2'b11};

    I_RESETN = 1'b0;
    clear_inputs();
    model_reset();
    repeat (3) @(negedge I_CLK);
    I_RESETN = 1'b1;
    #1;
    chk("reset_state", 64'(dut_out()), 64'h0);

    // Single owner, pass-through, drops, read path, round-robin tie.
    for (int i = 0; i < 13; i++) begin
      {R1_REQ, R0_REQ} = tbl[i].req;
      {R0_TX_EN, R0_WADDR, R0_WDATA, R0_RX_EN, R0_RADDR} = tbl[i].r0_bus;
      {R1_TX_EN, R1_WADDR, R1_WDATA, R1_RX_EN, R1_RADDR} = tbl[i].r1_bus;
      O_RDATA = tbl[i].rdata;
      sample();
      chk($sformatf("vec%0d", i),
          64'({R1_GNT, R0_GNT, I_TX_EN, I_WADDR, I_WDATA, I_RX_EN, I_RADDR, R0_RDATA, R1_RDATA, DROP_FLAG}),
          64'({tbl[i].e_gnt, tbl[i].e_core, tbl[i].e_r0d, tbl[i].e_r1d, tbl[i].e_drop}));
      tick();
    end
    clear_inputs();

    // Round robin from reset with simultaneous requests.
    do_reset();
    R0_REQ = 1'b1; R1_REQ = 1'b1;
    sample(); chk("rr_idle", 64'({R1_GNT, R0_GNT}), 64'(2'b00)); tick();
    sample(); chk("rr_r0_first", 64'({R1_GNT, R0_GNT}), 64'(2'b01)); tick();
    R0_REQ = 1'b0;
    step();
    sample(); chk("rr_gap", 64'(dut_out()), 64'h0); tick();
    step();
    sample(); chk("rr_r1_after_gap", 64'({R1_GNT, R0_GNT}), 64'(2'b10)); tick();
    R0_REQ = 1'b1;
    step();
    sample(); chk("rr_r1_keeps", 64'({R1_GNT, R0_GNT}), 64'(2'b10)); tick();
    R1_REQ = 1'b0;
    step();
    R1_REQ = 1'b1;
    step();
    step();
    sample(); chk("rr_r0_after_r1", 64'({R1_GNT, R0_GNT}), 64'(2'b01)); tick();
    R0_REQ = 1'b0; R1_REQ = 1'b0;
    repeat (3) step();

    // Watchdog expiry, forced STOP, blocking and re-grant.
    R0_REQ = 1'b1;
    step();
    gnt_cycles = 0;
    fell = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (R0_GNT) gnt_cycles++;
      else begin fell = 1'b1; break; end
      tick();
    end
    if (!fell) sample();
    chk("wd_hold_cycles", 64'(gnt_cycles), 64'(HM));
    chk("wd_stop_cmd", 64'({I_TX_EN, I_WADDR, I_WDATA, I_RX_EN}), 64'({1'b1, 3'b100, STOP, 1'b0}));
    chk("wd_to_flag", 64'(TO_FLAG), 64'(2'b01));
    tick();
    sample(); chk("wd_gap", 64'({R1_GNT, R0_GNT, I_TX_EN, I_RX_EN}), 64'h0); tick();
    sample(); chk("wd_r0_blocked_a", 64'({R1_GNT, R0_GNT}), 64'(2'b00)); tick();
    sample(); chk("wd_r0_blocked_b", 64'({R1_GNT, R0_GNT}), 64'(2'b00)); tick();
    R1_REQ = 1'b1;
    step();
    sample(); chk("wd_r1_granted", 64'({R1_GNT, R0_GNT}), 64'(2'b10)); tick();
    R0_REQ = 1'b0;
    step();
    R0_REQ = 1'b1;
    step();
    R1_REQ = 1'b0;
    step();
    step();
    step();
    sample(); chk("wd_r0_regrant", 64'({R1_GNT, R0_GNT}), 64'(2'b01)); tick();

    // Asynchronous reset in the middle of an R1 write.
    R0_REQ = 1'b0;
    step();
    R1_REQ = 1'b1;
    step();
    step();
    R1_TX_EN = 1'b1; R1_WADDR = 3'd2; R1_WDATA = 8'h5A;
    sample(); chk("rst_pre_tx", 64'({R1_GNT, I_TX_EN, I_WDATA}), 64'({1'b1, 1'b1, 8'h5A}));
    I_RESETN = 1'b0;
    #1;
    model_reset();
    chk("rst_tx", 64'(I_TX_EN), 64'h0);
    chk("rst_gnt", 64'({R1_GNT, R0_GNT}), 64'h0);
    chk("rst_flags", 64'({TO_FLAG, DROP_FLAG}), 64'h0);
    R1_TX_EN = 1'b0; R0_REQ = 1'b1; R1_REQ = 1'b1;
    tick();
    tick();
    I_RESETN = 1'b1;
    step();
    sample(); chk("rst_r0_first", 64'({R1_GNT, R0_GNT}), 64'(2'b01)); tick();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) R0_REQ = ~R0_REQ;
      if ($urandom_range(7) == 0) R1_REQ = ~R1_REQ;
      R0_TX_EN = ($urandom_range(2) == 0);
      R0_RX_EN = ($urandom_range(3) == 0);
      R1_TX_EN = ($urandom_range(2) == 0);
      R1_RX_EN = ($urandom_range(3) == 0);
      R0_WADDR = 3'($urandom); R0_RADDR = 3'($urandom); R0_WDATA = 8'($urandom);
      R1_WADDR = 3'($urandom); R1_RADDR = 3'($urandom); R1_WDATA = 8'($urandom);
      O_RDATA  = 8'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/iic_reg_arbiter.md
# iic_reg_arbiter

Shares the single register bus of the IIC master core (`I_TX_EN`/`I_WADDR`/`I_WDATA`/`I_RX_EN`/`I_RADDR`/`O_RDATA`) between two register-level sequencers, such as the EEPROM write/verify sequencer and a second configuration sequencer. A requester holds the bus for a whole IIC transaction, from START to STOP. Grants alternate round-robin. A hold-time watchdog revokes a stuck owner and forces a STOP command into the core, so the IIC bus is never left open.

## Interface
- `HOLD_MAX`, 16'd4096: maximum granted cycles per ownership; 0 disables the watchdog.
- `STOP_CMD`, 8'h40: data written to core CR (addr 3'b100) on abort.
- `I_CLK`  in  1  single clock, rising edge.
- `I_RESETN`  in  1  asynchronous, active-low reset.
- `R0_REQ`, `R1_REQ`  in  1 each  bus request; held high for the whole transaction.
- `R0_GNT`, `R1_GNT`  out  1 each  ownership; at most one high.
- `Rn_TX_EN` in 1, `Rn_WADDR` in 3, `Rn_WDATA` in 8  requester n register write strobe, address and data.
- `Rn_RX_EN` in 1, `Rn_RADDR` in 3  requester n register read strobe and address.
- `Rn_RDATA`  out  8  = `O_RDATA` while n owns the bus, else 0.
- `I_TX_EN` out 1, `I_WADDR` out 3, `I_WDATA` out 8, `I_RX_EN` out 1, `I_RADDR` out 3  to the core.
- `O_RDATA`  in  8  core read data.
- `TO_FLAG`  out  2  sticky; bit n set when requester n is revoked by the watchdog.
- `DROP_FLAG`  out  2  sticky; bit n set when requester n strobes TX_EN/RX_EN without a grant.

## Operation
- States: IDLE, OWN0, OWN1, ABORT, GAP. Registered state. `GNT` and `Rn_RDATA` are decoded from state. The core-side mux is combinational.
- Core outputs in IDLE, GAP and ABORT are all 0. The one exception is ABORT: `I_TX_EN`=1, `I_WADDR`=3'b100, `I_WDATA`=STOP_CMD.
- OWNn: core outputs = requester n signals unmodified; simultaneous TX_EN and RX_EN both pass through.
- Eligibility: requester n is eligible when `Rn_REQ`=1 and `blocked[n]`=0.
- IDLE transitions:
  - Only one requester eligible: go to its OWN state.
  - Both eligible: grant the requester that is not `last_owner`.
  - `last_owner` resets to 1, so R0 wins first.
- OWNn:
  - `Rn_REQ`=0 goes to GAP and sets `last_owner`=n.
  - Watchdog expiry with `Rn_REQ` still 1 goes to ABORT. It also sets `TO_FLAG[n]`, `blocked[n]`=1 and `last_owner`=n.
- ABORT lasts 1 cycle, then GAP. GAP lasts 1 cycle, then IDLE.
- `blocked[n]` clears on any cycle with `Rn_REQ`=0. A revoked requester must drop REQ once before it is re-granted.
- Watchdog: 16-bit `hold_cnt`.
  - Cleared on entry to OWNn; increments each OWNn cycle.
  - Expiry when `hold_cnt` == HOLD_MAX-1 and HOLD_MAX≠0.
  - Result: GNT is high for exactly HOLD_MAX cycles.
- Drops: `Rn_TX_EN` or `Rn_RX_EN` high while `Rn_GNT`=0 sets `DROP_FLAG[n]`; the strobe never reaches the core. This includes the owner's strobes during ABORT/GAP.
- Flags clear only on reset.

## Timing
- Reset (async assert, sync release) values:
  - State IDLE; `GNT`=0; all core outputs 0; `Rn_RDATA`=0.
  - `TO_FLAG`=0, `DROP_FLAG`=0, `blocked`=0, `last_owner`=1, `hold_cnt`=0.
- Grant latency: REQ sampled high in IDLE at edge k gives GNT high after edge k.
- A strobe presented in the first GNT-high cycle reaches the core in that same cycle (0-cycle pass-through).
- Read path is combinational, so the requester's existing "RX_EN, wait, sample O_RDATA" timing is preserved.
- Release: REQ low sampled at edge k gives GNT low after edge k. One GAP cycle follows, and the next GNT is no earlier than k+2.
- REQ rising in GAP is served at the IDLE decision that follows.
- Reset mid-ownership or mid-ABORT: outputs go to 0 immediately, with no STOP emitted.

## Test plan
1. R0_REQ=1 after reset.
   - Expect R0_GNT after 1 edge.
   - R0 write WADDR=0, WDATA=0x63 appears on I_WADDR/I_WDATA with I_TX_EN=1 in the same cycle.
   - R0_REQ=0: GNT drops, one GAP cycle with all core outputs 0.
2. R0_REQ and R1_REQ both rise in the same cycle from reset.
   - R0 granted first.
   - On R0 release: GAP, then R1_GNT.
   - R0 re-requests while R1 holds: after R1 releases, R0 is granted.
3. R1 pulses R1_TX_EN (WADDR=3, WDATA=0xA0) while R0 owns.
   - Core sees R0 signals only.
   - DROP_FLAG=2'b10; DROP_FLAG stays set after the R0 release.
4. HOLD_MAX=8, R0 holds REQ.
   - R0_GNT high exactly 8 cycles.
   - Next cycle: I_TX_EN=1, I_WADDR=4, I_WDATA=0x40.
   - TO_FLAG=2'b01; then GAP.
   - R0_REQ still high is not re-granted; R1_REQ=1 gets R1_GNT.
   - R0 drops REQ for 1 cycle and re-raises: R0 is granted after R1 releases.
5. Assert I_RESETN=0 during OWN1 with R1_TX_EN=1.
   - Expect I_TX_EN=0, GNT=0 and flags=0 immediately.
   - After release with both REQ high: R0 granted.
6. R0 owns and reads SR: R0_RX_EN=1, R0_RADDR=4, O_RDATA driven 0x02.
   - R0_RDATA=0x02; R1_RDATA=0.
